result_row_collector: RTL

Result-side sink for the vXc compute engine. It accepts the engine's 512-bit result rows, each with a write-enable and a write-address counter, and stores them in an internal row buffer. When the engine signals finish, or the expected row count is reached, it drains the rows in address order over a valid/ready stream, then raises a sticky done flag. It is the consuming end of the engine's result-memory write interface (we / address counter / row data).

---
 rtl/result_row_collector_pkg.sv | 25 ++
 rtl/result_row_ram.sv | 38 +++
 rtl/result_row_collector.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/result_row_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_row_collector_pkg
//  Description : Shared types and constants for the result row collector and
//                the vXc compute engine result-memory write interface.
//                State enum, row and lane widths, and the default row-count
//                and address widths that also size the engine's counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package result_row_collector_pkg;

    localparam int ROW_WIDTH          = 64 * 8;
    localparam int LANE_WIDTH         = 32;
    localparam int DEFAULT_NUM_ROWS   = 16;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : result_row_collector_pkg
`default_nettype wire

// File: rtl/result_row_ram.sv
`default_nettype none
// ============================================================================
//  Module      : result_row_ram
//  Description : Row buffer, 2**ADDR_WIDTH x DATA_WIDTH, one synchronous
//                write port and one asynchronous read port. Contents are not
//                reset; the owner tracks row validity separately.
//  Ports       : clk      - rising-edge clock
//                i_we     - write enable
//                i_waddr  - write row index
//                i_wdata  - write row data
//                i_raddr  - read row index
//                o_rdata  - read row data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module result_row_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : result_row_ram
`default_nettype wire

// File: rtl/result_row_collector.sv
`default_nettype none
// ============================================================================
//  Module      : result_row_collector
//  Description : Consumes the engine's result rows (we / address / data) into
//                a row buffer, then drains NUM_ROWS rows in address order on
//                a valid/ready stream once the engine finishes or every row
//                has been written. Unwritten rows drain as zero.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                result_mem_we      - row write strobe
//                write_address      - engine write counter
//                write_data         - row data
//                engine_finish      - engine finished
//                out_ready          - downstream ready
//                out_valid/out_data/out_address - drained row stream
//                row_count          - distinct rows written
//                drain_done         - sticky, all rows delivered
//                write_err          - sticky, a write was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module result_row_collector
    import result_row_collector_pkg::*;
#(
    parameter int DATA_WIDTH = ROW_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_ROWS   = DEFAULT_NUM_ROWS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  result_mem_we,
    input  logic [31:0]           write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  engine_finish,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_address,
    output logic [ADDR_WIDTH:0]   row_count,
    output logic                  drain_done,
    output logic                  write_err
);

    localparam int                    c_DEPTH      = 2**ADDR_WIDTH;
    localparam logic [31:0]           c_NUM_ROWS_W = 32'(NUM_ROWS);
    localparam logic [ADDR_WIDTH:0]   c_NUM_ROWS_C = (ADDR_WIDTH+1)'(NUM_ROWS);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_RP    = ADDR_WIDTH'(NUM_ROWS - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_DEPTH-1:0]    r_valid;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH:0]   r_row_count;
    logic                  r_done;
    logic                  r_err;

    logic                  w_collecting;
    logic                  w_in_range;
    logic                  w_wr_ok;
    logic                  w_new_row;
    logic                  w_count_full;
    logic                  w_handshake;
    logic                  w_last;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_rd_ptr;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Range check uses the full 32-bit counter so wrapped addresses are
    // rejected rather than aliased onto low rows.
    assign w_collecting = (r_state == IDLE) || (r_state == COLLECT);
    assign w_in_range   = (write_address < c_NUM_ROWS_W);
    assign w_waddr      = write_address[ADDR_WIDTH-1:0];
    assign w_wr_ok      = result_mem_we && w_collecting && w_in_range;
    assign w_new_row    = w_wr_ok && !r_valid[w_waddr];
    assign w_count_full = w_new_row &&
                          ((r_row_count + (ADDR_WIDTH+1)'(1)) == c_NUM_ROWS_C);

    assign w_handshake  = r_out_valid && out_ready;
    assign w_last       = w_handshake && (r_rp == c_LAST_RP);

    // Load the output register when it is empty or its row is being taken;
    // reading one row ahead keeps back-to-back delivery at one row per cycle.
    assign w_load       = (r_state == DRAIN) &&
                          (!r_out_valid || (w_handshake && !w_last));
    assign w_rd_ptr     = w_handshake ? (r_rp + ADDR_WIDTH'(1)) : r_rp;

    result_row_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (w_waddr),
        .i_wdata (write_data),
        .i_raddr (w_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The write of the current cycle is committed by the datapath on the same
    // edge the state leaves COLLECT, so a simultaneous finish keeps the row.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, COLLECT: begin
                if (engine_finish || w_count_full) begin
                    w_next_state = DRAIN;
                end else if (result_mem_we) begin
                    w_next_state = COLLECT;
                end
            end
            DRAIN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_rp        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_row_count <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_valid[w_waddr] <= 1'b1;
            end
            r_row_count <= r_row_count + {{ADDR_WIDTH{1'b0}}, w_new_row};

            if (result_mem_we && !w_wr_ok) begin
                r_err <= 1'b1;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_valid[w_rd_ptr] ? w_rd_data : '0;
            end else if (w_last) begin
                r_out_valid <= 1'b0;
            end

            if (w_handshake && !w_last) begin
                r_rp <= r_rp + ADDR_WIDTH'(1);
            end

            if (w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_address = r_rp;
    assign row_count   = r_row_count;
    assign drain_done  = r_done;
    assign write_err   = r_err;

endmodule : result_row_collector
`default_nettype wire
